mmu_tlb: RTL
============

// Module: mmu_tlb
// PURPOSE
//  Associative translation memory (MA) of the MMU, directly upstream of the
//  MMU control unit: produces the esito_ma hit/miss outcome and the physical
//  page for each lookup. Filled from the page-table path on the control unit's
//  cl/s strobes; cleared by the control unit's flush strobe.
// PARAMETERS
//  ENTRIES  8   number of fully-associative entries (power of 2, >=2)
//  VPN_W    16  virtual page number width
//  PPN_W    12  physical page number width
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  reset      in   1       asynchronous, active-high reset
//  lk_rdy     in   1       lookup request pulse (1 cycle)
//  lk_vpn     in   VPN_W   virtual page to translate, valid with lk_rdy
//  lk_ack     out  1       lookup response pulse (1 cycle)
//  esito_ma   out  1       1 = miss, 0 = hit; valid with lk_ack
//  ma_ppn     out  PPN_W   translated page; valid with lk_ack when esito_ma=0
//  ins_en     in   1       insert strobe (driven by control unit cl/s)
//  ins_vpn    in   VPN_W   virtual page to insert
//  ins_ppn    in   PPN_W   physical page to insert
//  flush_en   in   1       flush strobe (driven by control unit flush)
//  flush_done out  1       1-cycle pulse when flush completes
//  busy       out  1       1 while in FLUSH
// BEHAVIOUR
//  - Reset (async, active-high): all valid bits 0, rr pointer 0, state IDLE,
//    pend 0; lk_ack/esito_ma/ma_ppn/flush_done/busy all 0.
//  - States: IDLE, FLUSH. IDLE->FLUSH on flush_en (idx<=0). FLUSH clears
//    valid[idx] per cycle; on idx==ENTRIES-1 -> IDLE, flush_done=1 next cycle.
//    Flush takes ENTRIES cycles; busy=1 throughout.
//  - Lookup in IDLE: compare lk_vpn to all valid entries in the request cycle;
//    lk_ack=1 one cycle later with registered esito_ma/ma_ppn. Back-to-back
//    lookups accepted every cycle. On miss ma_ppn=0.
//  - Lookup while in FLUSH or same cycle as flush_en: latched in pend (vpn
//    held); serviced in first IDLE cycle after flush -> always miss. A second
//    lk_rdy while pend=1 is a protocol violation (ignored, bench asserts).
//    If lk_rdy arrives in the same cycle pend is serviced, pend wins; new one dropped.
//  - Insert (IDLE only): if ins_vpn matches a valid entry, overwrite its ppn,
//    rr unchanged; else write {1,ins_vpn,ins_ppn} at rr, rr<=(rr+1) mod
//    ENTRIES (wraps ENTRIES-1 -> 0, overwriting oldest). No duplicate VPNs.
//  - Insert during FLUSH or same cycle as flush_en: dropped. Flush wins.
//  - Lookup and insert same cycle: lookup sees pre-insert contents unless
//    MMU_TLB_BYPASS_EN (see below).
//  - flush_en while in FLUSH: ignored (no restart).
//  - Reset mid-FLUSH or mid-lookup: all aborted, state as after reset.
// CONFIGURATION
//  MMU_TLB_BYPASS_EN defined: lookup coinciding with accepted insert and
//   lk_vpn==ins_vpn returns hit with ma_ppn=ins_ppn (forwarded).
//  Undefined: same case returns pre-insert contents (miss if VPN was absent,
//   old PPN if present). No other behavioural difference.
// TESTING
//  1 reset, lookup vpn 0x0010 -> lk_ack next cycle, esito_ma=1, ma_ppn=0.
//  2 insert 0x0010->0x0A5, then lookup 0x0010 -> esito_ma=0, ma_ppn=0x0A5;
//    insert 0x0010->0x0B6 -> lookup gives 0x0B6, rr still 1.
//  3 insert 9 distinct vpns 0x100..0x108 (ENTRIES=8) -> 0x100 misses,
//    0x101..0x108 hit; rr=1.
//  4 fill 4 entries, flush_en + lk_rdy(0x101) same cycle -> busy 8 cycles,
//    flush_done pulse, then lk_ack with esito_ma=1; insert during flush dropped.
//  5 lookup+insert 0x0200->0x3C same cycle -> miss without MMU_TLB_BYPASS_EN,
//    hit 0x3C with it; following lookup hits 0x3C in both builds.
//  6 assert reset in 3rd flush cycle -> all outputs 0 immediately, later
//    lookup of previously inserted vpn misses, no flush_done pulse.

Source files
------------

// File: rtl/mmu_tlb.sv
// Fully-associative MMU translation buffer with round-robin fill and sequential flush.
// Optional MMU_TLB_BYPASS_EN forwards a same-cycle insert to a matching lookup.
module mmu_tlb #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned VPN_W   = 16,
    parameter int unsigned PPN_W   = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lk_rdy,
    input  logic [VPN_W-1:0] lk_vpn,
    output logic             lk_ack,
    output logic             esito_ma,
    output logic [PPN_W-1:0] ma_ppn,
    input  logic             ins_en,
    input  logic [VPN_W-1:0] ins_vpn,
    input  logic [PPN_W-1:0] ins_ppn,
    input  logic             flush_en,
    output logic             flush_done,
    output logic             busy
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [VPN_W-1:0]   tag_q  [ENTRIES];
    logic [VPN_W-1:0]   tag_d  [ENTRIES];
    logic [PPN_W-1:0]   data_q [ENTRIES];
    logic [PPN_W-1:0]   data_d [ENTRIES];
    logic               pend_q, pend_d;
    logic               lk_ack_q, lk_ack_d;
    logic               esito_q, esito_d;
    logic [PPN_W-1:0]   ppn_q, ppn_d;
    logic               flush_done_q, flush_done_d;
    logic               busy_q, busy_d;

    logic               lk_hit;
    logic [PPN_W-1:0]   lk_ppn;
    logic               ins_hit;
    logic [IDX_W-1:0]   ins_idx;

    // Parallel tag match for both the lookup and the insert port (pre-insert contents).
    always_comb begin
        lk_hit  = 1'b0;
        lk_ppn  = '0;
        ins_hit = 1'b0;
        ins_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == lk_vpn)) begin
                lk_hit = 1'b1;
                lk_ppn = data_q[i];
            end
            if (valid_q[i] && (tag_q[i] == ins_vpn)) begin
                ins_hit = 1'b1;
                ins_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rr_d         = rr_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        pend_d       = pend_q;
        lk_ack_d     = 1'b0;
        esito_d      = 1'b0;
        ppn_d        = '0;
        flush_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A parked lookup only ever follows a flush, so it always misses.
                if (pend_q) begin
                    lk_ack_d = 1'b1;
                    esito_d  = 1'b1;
                    pend_d   = 1'b0;
                end else if (lk_rdy) begin
                    if (flush_en) begin
                        pend_d = 1'b1;
                    end else begin
                        lk_ack_d = 1'b1;
                        esito_d  = ~lk_hit;
                        ppn_d    = lk_hit ? lk_ppn : '0;
`ifdef MMU_TLB_BYPASS_EN
                        if (ins_en && (ins_vpn == lk_vpn)) begin
                            esito_d = 1'b0;
                            ppn_d   = ins_ppn;
                        end
`endif
                    end
                end

                if (flush_en) begin
                    state_d = S_FLUSH;
                    idx_d   = '0;
                end else if (ins_en) begin
                    if (ins_hit) begin
                        data_d[ins_idx] = ins_ppn;
                    end else begin
                        valid_d[rr_q] = 1'b1;
                        tag_d[rr_q]   = ins_vpn;
                        data_d[rr_q]  = ins_ppn;
                        rr_d          = rr_q + 1'b1;
                    end
                end
            end

            S_FLUSH: begin
                valid_d[idx_q] = 1'b0;
                if (lk_rdy && !pend_q) begin
                    pend_d = 1'b1;
                end
                if (idx_q == IDX_W'(ENTRIES - 1)) begin
                    state_d      = S_IDLE;
                    flush_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_FLUSH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            rr_q         <= '0;
            valid_q      <= '0;
            pend_q       <= 1'b0;
            lk_ack_q     <= 1'b0;
            esito_q      <= 1'b0;
            ppn_q        <= '0;
            flush_done_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rr_q         <= rr_d;
            valid_q      <= valid_d;
            pend_q       <= pend_d;
            lk_ack_q     <= lk_ack_d;
            esito_q      <= esito_d;
            ppn_q        <= ppn_d;
            flush_done_q <= flush_done_d;
            busy_q       <= busy_d;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign lk_ack     = lk_ack_q;
    assign esito_ma   = esito_q;
    assign ma_ppn     = ppn_q;
    assign flush_done = flush_done_q;
    assign busy       = busy_q;
endmodule
